// File: rtl/wb_master_port.sv
// ============================================================================
// wb_master_port : single-outstanding Wishbone B3 classic master with monitor
// port. Optional ack watchdog enabled by defining WB_ACK_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_master_port #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_adr,
  input  logic [DATA_WIDTH-1:0] req_dat,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_dat,
  output logic                  resp_err,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  mon_valid,
  output logic [ADDR_WIDTH-1:0] mon_adr,
  output logic [DATA_WIDTH-1:0] mon_dat,
  output logic                  mon_we
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_bus   = 2'd1;
`ifdef WB_ACK_TIMEOUT_EN
  localparam logic [1:0] c_st_abort = 2'd2;
  localparam int         c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_tmo_cnt;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  logic [1:0] r_state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= c_st_idle;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_dat   <= '0;
      resp_err   <= 1'b0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      mon_valid  <= 1'b0;
      mon_adr    <= '0;
      mon_dat    <= '0;
      mon_we     <= 1'b0;
`ifdef WB_ACK_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      mon_valid  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (req_valid && req_ready) begin
            we_o      <= req_we;
            adr_o     <= req_adr;
            dat_o     <= req_we ? req_dat : '0;
            cyc_o     <= 1'b1;
            stb_o     <= 1'b1;
            req_ready <= 1'b0;
            r_state   <= c_st_bus;
`ifdef WB_ACK_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end else begin
            req_ready <= 1'b1;
          end
        end
        c_st_bus: begin
          // ack has priority over a watchdog expiry on the same edge
          if (ack_i) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_dat   <= we_o ? '0 : dat_i;
            mon_valid  <= 1'b1;
            mon_adr    <= adr_o;
            mon_dat    <= we_o ? dat_o : dat_i;
            mon_we     <= we_o;
            r_state    <= c_st_idle;
          end
`ifdef WB_ACK_TIMEOUT_EN
          else if (r_tmo_cnt == c_cnt_last) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_dat   <= '0;
            r_state    <= c_st_abort;
          end else begin
            r_tmo_cnt  <= r_tmo_cnt + 1'b1;
          end
`endif
        end
`ifdef WB_ACK_TIMEOUT_EN
        c_st_abort: begin
          req_ready <= 1'b1;
          r_state   <= c_st_idle;
        end
`endif
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_port.sv
// ============================================================================
// tb_wb_master_port : directed self-checking bench for wb_master_port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_master_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_adr = '0;
  logic [7:0] req_dat = '0;
  logic       resp_valid;
  logic [7:0] resp_dat;
  logic       resp_err;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic       ack_i = 1'b0;
  logic [7:0] dat_i = '0;
  logic       mon_valid;
  logic [1:0] mon_adr;
  logic [7:0] mon_dat;
  logic       mon_we;

  int passes = 0;
  int checks = 0;

  // slave model controls
  int  ack_wait = 0;
  bit  ack_tied = 1'b0;
  bit  spur     = 1'b0;
  int  k        = 0;

  // bus observers
  int  cyc_hi = 0, cyc_rise = 0, resp_cnt = 0, mon_cnt = 0;
  bit  cyc_prev = 1'b0;

  always #5 clk = ~clk;

  wb_master_port #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat),
    .resp_valid(resp_valid), .resp_dat(resp_dat), .resp_err(resp_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i),
    .mon_valid(mon_valid), .mon_adr(mon_adr), .mon_dat(mon_dat), .mon_we(mon_we)
  );

  // slave acks in the (ack_wait+1)-th cycle of a strobe
  always @(negedge clk) begin
    if (cyc_o && stb_o) k = k + 1;
    else k = 0;
    ack_i = ack_tied || spur || (cyc_o && stb_o && (k > ack_wait));
  end

  always @(negedge clk) begin
    if (cyc_o) cyc_hi = cyc_hi + 1;
    if (cyc_o && !cyc_prev) cyc_rise = cyc_rise + 1;
    cyc_prev = cyc_o;
    if (resp_valid) resp_cnt = resp_cnt + 1;
    if (mon_valid) mon_cnt = mon_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) begin
      passes = passes + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns just after the handshake edge
  task automatic issue(input logic we, input logic [1:0] adr, input logic [7:0] dat);
    int n;
    req_we = we; req_adr = adr; req_dat = dat; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    if (n >= 200) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    if (n >= 200) check("resp_timeout", 32'd0, 32'd1);
  endtask

  int c0, r0, p0, m0;

  initial begin
    // reset state
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_cyc", 32'(cyc_o), 32'd0);
    check("rst_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(req_ready), 32'd1);

    // single write, slave waits 2 cycles
    ack_wait = 2;
    c0 = cyc_hi; p0 = resp_cnt;
    issue(1'b1, 2'd0, 8'hC0);
    check("w0_bus", {cyc_o, stb_o, we_o, req_ready, 2'b00, adr_o, dat_o}, {4'b1110, 4'b0000, 8'hC0});
    wait_resp();
    check("w0_cyc_len", 32'(cyc_hi - c0), 32'd3);
    check("w0_resp", {resp_err, resp_dat}, {1'b0, 8'h00});
    check("w0_mon", {mon_valid, mon_we, mon_adr, mon_dat}, {1'b1, 1'b1, 2'd0, 8'hC0});
    check("w0_ready_back", {req_ready, cyc_o}, 2'b10);
    @(posedge clk); #1;
    check("w0_one_resp", 32'(resp_cnt - p0), 32'd1);

    // DPR write, CMDR write, CMDR read
    ack_wait = 1; dat_i = 8'h80;
    r0 = cyc_rise; m0 = mon_cnt;
    issue(1'b1, 2'd1, 8'h05); wait_resp();
    check("dpr_mon", {mon_we, mon_adr, mon_dat}, {1'b1, 2'd1, 8'h05});
    issue(1'b1, 2'd2, 8'h06); wait_resp();
    check("cmdr_mon", {mon_we, mon_adr, mon_dat}, {1'b1, 2'd2, 8'h06});
    issue(1'b0, 2'd2, 8'hFF);
    check("rd_dat_o", {we_o, dat_o}, {1'b0, 8'h00});
    wait_resp();
    check("rd_resp", {resp_err, resp_dat}, {1'b0, 8'h80});
    check("rd_mon", {mon_we, mon_adr, mon_dat}, {1'b0, 2'd2, 8'h80});
    @(posedge clk); #1;
    check("seq_cycles", 32'(cyc_rise - r0), 32'd3);
    check("seq_mons", 32'(mon_cnt - m0), 32'd3);

    // zero-wait slave, ack tied high, back-to-back writes
    c0 = cyc_hi; r0 = cyc_rise; p0 = resp_cnt; m0 = mon_cnt;
    ack_tied = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 2'd1, 8'h44);
    issue(1'b1, 2'd1, 8'h78);
    repeat (4) @(posedge clk); #1;
    check("zw_cyc_hi", 32'(cyc_hi - c0), 32'd2);
    check("zw_cyc_rise", 32'(cyc_rise - r0), 32'd2);
    check("zw_resps", 32'(resp_cnt - p0), 32'd2);
    check("zw_mons", 32'(mon_cnt - m0), 32'd2);
    check("zw_last_mon", {mon_we, mon_adr, mon_dat}, {1'b1, 2'd1, 8'h78});
    ack_tied = 1'b0;

    // spurious acks while idle
    @(posedge clk); #1;
    p0 = resp_cnt; m0 = mon_cnt;
    spur = 1'b1;
    repeat (4) @(posedge clk);
    #1 spur = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("spur_resp", 32'(resp_cnt - p0), 32'd0);
    check("spur_mon", 32'(mon_cnt - m0), 32'd0);

    // reset mid-bus
    ack_wait = 100;
    issue(1'b1, 2'd3, 8'hAA);
    @(posedge clk); #3;
    p0 = resp_cnt; m0 = mon_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {cyc_o, stb_o, we_o, req_ready}, 4'b0000);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_noresp", 32'(resp_cnt - p0), 32'd0);
    check("mid_rst_nomon", 32'(mon_cnt - m0), 32'd0);
    ack_wait = 0; dat_i = 8'h3C;
    issue(1'b0, 2'd1, 8'h00);
    wait_resp();
    check("post_rst_rd", {resp_err, resp_dat}, {1'b0, 8'h3C});
    check("post_rst_mon", {mon_valid, mon_we, mon_adr, mon_dat}, {1'b1, 1'b0, 2'd1, 8'h3C});

`ifdef WB_ACK_TIMEOUT_EN
    // slave never acks: watchdog abort after 16 bus cycles
    @(posedge clk); #1;
    ack_wait = 10000;
    c0 = cyc_hi; m0 = mon_cnt;
    issue(1'b1, 2'd0, 8'h5A);
    wait_resp();
    check("tmo_cyc_len", 32'(cyc_hi - c0), 32'd16);
    check("tmo_resp", {resp_err, resp_dat, cyc_o}, {1'b1, 8'h00, 1'b0});
    @(posedge clk); #1;
    check("tmo_nomon", 32'(mon_cnt - m0), 32'd0);
    @(posedge clk); #1;
    check("tmo_ready", 32'(req_ready), 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
Synthesizable single-outstanding Wishbone B3 classic master, the hardware counterpart of the team's Wishbone master BFM. It takes read and write requests from a local request/response handshake and drives the Wishbone bus, e.g. into the iicmb controller's CSR/DPR/CMDR/FSMR registers. It also publishes every completed transfer on a monitor port for the transcript and scoreboard.

Parameters:
ADDR_WIDTH, 2, width of adr_o and req_adr.
DATA_WIDTH, 8, width of dat_o, dat_i, request and response data.
TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with WB_ACK_TIMEOUT_EN.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  asynchronous reset, active-low.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid and req_ready are both high.
req_we  in  1  1 = write, 0 = read.
req_adr  in  ADDR_WIDTH  register address.
req_dat  in  DATA_WIDTH  write data.
resp_valid  out  1  one-cycle completion pulse.
resp_dat  out  DATA_WIDTH  read data; 0 for writes.
resp_err  out  1  transfer aborted by timeout; qualified by resp_valid.
cyc_o  out  1  Wishbone cycle.
stb_o  out  1  Wishbone strobe.
we_o  out  1  Wishbone write enable.
adr_o  out  ADDR_WIDTH  Wishbone address.
dat_o  out  DATA_WIDTH  Wishbone write data.
ack_i  in  1  Wishbone acknowledge.
dat_i  in  DATA_WIDTH  Wishbone read data.
mon_valid  out  1  one-cycle pulse per acked transfer.
mon_adr  out  ADDR_WIDTH  monitored address.
mon_dat  out  DATA_WIDTH  monitored data: dat_o on writes, dat_i on reads.
mon_we  out  1  monitored direction.

Behaviour:
- All outputs are registered.
- Reset (rst_i low, asynchronous): every output is 0 except req_ready, which is also 0 while reset is asserted. State returns to IDLE. A bus cycle in progress is dropped immediately, with no response and no monitor pulse.
- States: IDLE, BUS, plus ABORT when the optional feature is present.
- IDLE:
  - req_ready = 1.
  - On handshake: capture req_we, req_adr and req_dat into we_o, adr_o and dat_o. dat_o = 0 for reads.
  - Next cycle cyc_o = stb_o = 1 and state = BUS.
- BUS:
  - req_ready = 0; cyc_o, stb_o, adr_o, we_o and dat_o are held stable.
  - On a rising edge with ack_i = 1:
    - cyc_o and stb_o go to 0, we_o goes to 0, state = IDLE.
    - resp_valid = 1 for one cycle with resp_err = 0. resp_dat = dat_i sampled at that edge for reads, 0 for writes.
    - mon_valid = 1 for the same cycle, with mon_adr, mon_dat and mon_we as defined above.
- Latency: request accept edge to first cyc_o-high cycle is 1 cycle. Ack edge to resp_valid is 0 extra cycles (registered on the ack edge).
- Back-to-back transfers: req_ready reasserts in the cycle resp_valid is high, so a new handshake is possible then. cyc_o is therefore low for at least one full cycle between transfers.
- ack_i while in IDLE is ignored: no response, no monitor pulse.
- ack_i held high continuously: each transfer still completes exactly once. The next transfer completes on its first BUS-cycle edge (zero-wait slave).
- adr_o, dat_o and mon_* keep their last values when idle; only the qualifiers drop.
- No retry or error inputs; err_i/rty_i are not supported.

Optional Feature:
- Macro: WB_ACK_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to BUS and increments each BUS cycle without ack_i.
  - When it reaches TIMEOUT_CYCLES, cyc_o and stb_o drop and the block enters ABORT for one cycle.
  - resp_valid = 1 with resp_err = 1 and resp_dat = 0; no mon_valid pulse; then IDLE.
  - An ack_i on the same edge as expiry wins, giving a normal completion.
- Without the macro: BUS waits for ack_i indefinitely, resp_err is constant 0, and the counter does not exist.

Test Plan:
- Reset release, then write adr 0 data 0xC0 with a slave acking after 2 cycles:
  - cyc/stb high for exactly 3 cycles with adr_o = 0, we_o = 1, dat_o = 0xC0.
  - resp_valid pulses once; mon shows 0/0xC0/1.
- Sequence write DPR(1) = 0x05, write CMDR(2) = 0x06, read CMDR:
  - three transfers in order, each separated by at least one cyc-low cycle.
  - The read returns the slave's dat_i (e.g. 0x80) on resp_dat and mon_dat, with mon_we = 0.
- Zero-wait slave (ack_i tied high), writes 0x44 then 0x78 to adr 1 issued back-to-back:
  - each cyc pulse lasts 1 cycle; exactly two resp_valid and two mon_valid pulses.
- rst_i driven low mid-BUS:
  - cyc_o, stb_o, we_o and req_ready are 0 within the same time step; no resp_valid.
  - After release, a new read completes normally.
- Spurious ack_i pulses while IDLE: no resp_valid or mon_valid.
- With WB_ACK_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never acks:
  - cyc drops after 16 BUS cycles; resp_valid = 1, resp_err = 1, resp_dat = 0; no mon_valid.
